lavatory_scheduler: RTL

//  Sequential scheduler for the three aircraft lavatories. Lavatory 0 is women-only; 1 and 2 are shared.

---
 rtl/lavatory_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lavatory_scheduler.sv
// ----------------------------------------------------------------------------
// lavatory_scheduler
//
// Purpose:
//   Sequential scheduler for the three aircraft lavatories. Lavatory 0 is for
//   women only; lavatories 1 and 2 are shared. The block counts the women and
//   men waiting and assigns free lavatories, at most one per cycle. A granted
//   lavatory stays reserved until its door lock closes or the reservation
//   times out. It also drives the "free for women" and "free for men" signs.
//
// Parameters:
//   QBITS    width of each wait counter (queue capacity 2**QBITS-1)
//   TIMEOUT  cycles a reservation is held without the lock closing
//            (1..2**TBITS-1)
//   TBITS    width of the per-lavatory reservation timer
//
// Ports:
//   clk_2        in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   lock[2:0]    in   door-lock sensors, 1 = lavatory locked/occupied
//   req_f        in   1-cycle pulse: a woman joins the queue
//   req_m        in   1-cycle pulse: a man joins the queue
//   grant_valid  out  1-cycle pulse: a lavatory was assigned
//   grant_lav    out  assigned lavatory index (valid with grant_valid)
//   grant_fem    out  1 = granted to a woman, 0 = to a man
//   timeout_evt  out  1-cycle pulse: a reservation expired unused
//   wait_f       out  women waiting
//   wait_m       out  men waiting
//   qfull_f      out  women queue at capacity
//   qfull_m      out  men queue at capacity
//   led_free_f   out  some lavatory is usable by a woman
//   led_free_m   out  lavatory 1 or 2 is usable by a man
// ----------------------------------------------------------------------------
module lavatory_scheduler #(
    parameter int QBITS   = 3,
    parameter int TIMEOUT = 15,
    parameter int TBITS   = 4
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic [2:0]       lock,
    input  logic             req_f,
    input  logic             req_m,
    output logic             grant_valid,
    output logic [1:0]       grant_lav,
    output logic             grant_fem,
    output logic             timeout_evt,
    output logic [QBITS-1:0] wait_f,
    output logic [QBITS-1:0] wait_m,
    output logic             qfull_f,
    output logic             qfull_m,
    output logic             led_free_f,
    output logic             led_free_m
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESERVED = 2'd1,
        OCCUPIED = 2'd2
    } lav_state_t;

    localparam logic [QBITS-1:0] QMAX  = '1;
    // Timer value seen in the last reserved cycle; the reservation therefore
    // lasts exactly TIMEOUT cycles when the lock never closes.
    localparam logic [TBITS-1:0] TLAST = TBITS'(TIMEOUT - 1);

    lav_state_t       r_state [3];
    logic [TBITS-1:0] r_timer [3];
    logic [QBITS-1:0] r_wait_f;
    logic [QBITS-1:0] r_wait_m;
    logic             r_rr_fem;     // 1 = women win the next contested shared grant
    logic             r_grant_valid;
    logic [1:0]       r_grant_lav;
    logic             r_grant_fem;
    logic             r_timeout_evt;
    logic             r_qfull_f;
    logic             r_qfull_m;
    logic             r_led_free_f;
    logic             r_led_free_m;

    logic [2:0]       w_usable;
    logic [2:0]       w_expire;
    logic             w_f_nz;
    logic             w_m_nz;
    logic             w_grant;
    logic [1:0]       w_grant_lav;
    logic             w_grant_fem;
    logic             w_rr_toggle;
    logic [QBITS-1:0] w_wait_f_nxt;
    logic [QBITS-1:0] w_wait_m_nxt;

    // A lavatory is usable only when idle and its lock is open this cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_usable[i] = (r_state[i] == IDLE) && !lock[i];
            w_expire[i] = (r_state[i] == RESERVED) && !lock[i] && (r_timer[i] == TLAST);
        end
    end

    assign w_f_nz = (r_wait_f != '0);
    assign w_m_nz = (r_wait_m != '0);

    // Arbitration: the women-only lavatory first, then the lowest free shared
    // one; the round-robin pointer only matters when both queues wait.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_grant     = 1'b0;
        w_grant_lav = 2'd0;
        w_grant_fem = 1'b0;
        w_rr_toggle = 1'b0;
        if (w_usable[0] && w_f_nz) begin
            w_grant     = 1'b1;
            w_grant_lav = 2'd0;
            w_grant_fem = 1'b1;
        end else if ((w_usable[1] || w_usable[2]) && (w_f_nz || w_m_nz)) begin
            w_grant     = 1'b1;
            w_grant_lav = w_usable[1] ? 2'd1 : 2'd2;
            if (w_f_nz && w_m_nz) begin
                w_grant_fem = r_rr_fem;
                w_rr_toggle = 1'b1;
            end else begin
                w_grant_fem = w_f_nz;
            end
        end
    end

    // A request and a grant of the same sex cancel, even at capacity, because
    // the grant frees the slot the request takes. Requests at capacity drop.
    function automatic logic [QBITS-1:0] next_count(input logic [QBITS-1:0] cnt,
                                                    input logic             req,
                                                    input logic             grant);
        if (req && grant)
            return cnt;
        else if (req && (cnt != QMAX))
            return cnt + QBITS'(1);
        else if (grant)
            return cnt - QBITS'(1);
        else
            return cnt;
    endfunction

    assign w_wait_f_nxt = next_count(r_wait_f, req_f, w_grant &&  w_grant_fem);
    assign w_wait_m_nxt = next_count(r_wait_m, req_m, w_grant && !w_grant_fem);

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-lavatory state and timer arrays are reset like any
            // other register; they are FSM state, not storage, and must come
            // up defined.
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= IDLE;
                r_timer[i] <= '0;
            end
            r_wait_f      <= '0;
            r_wait_m      <= '0;
            r_rr_fem      <= 1'b1;
            r_grant_valid <= 1'b0;
            r_grant_lav   <= 2'd0;
            r_grant_fem   <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_qfull_f     <= 1'b0;
            r_qfull_m     <= 1'b0;
            r_led_free_f  <= 1'b0;
            r_led_free_m  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values and ordering inside the block is free.
            for (int i = 0; i < 3; i++) begin
                unique case (r_state[i])
                    IDLE: begin
                        if (w_grant && (w_grant_lav == 2'(i))) begin
                            r_state[i] <= RESERVED;
                            r_timer[i] <= '0;
                        end else if (lock[i]) begin
                            r_state[i] <= OCCUPIED;
                        end
                    end
                    RESERVED: begin
                        if (lock[i])
                            r_state[i] <= OCCUPIED;
                        else if (w_expire[i])
                            r_state[i] <= IDLE;
                        else
                            r_timer[i] <= r_timer[i] + TBITS'(1);
                    end
                    OCCUPIED: begin
                        if (!lock[i])
                            r_state[i] <= IDLE;
                    end
                    default: r_state[i] <= IDLE;
                endcase
            end

            if (w_rr_toggle)
                r_rr_fem <= ~r_rr_fem;

            r_wait_f      <= w_wait_f_nxt;
            r_wait_m      <= w_wait_m_nxt;
            r_qfull_f     <= (w_wait_f_nxt == QMAX);
            r_qfull_m     <= (w_wait_m_nxt == QMAX);
            r_grant_valid <= w_grant;
            r_grant_lav   <= w_grant ? w_grant_lav : 2'd0;
            r_grant_fem   <= w_grant && w_grant_fem;
            r_timeout_evt <= |w_expire;
            r_led_free_f  <= |w_usable;
            r_led_free_m  <= w_usable[1] | w_usable[2];
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_lav   = r_grant_lav;
    assign grant_fem   = r_grant_fem;
    assign timeout_evt = r_timeout_evt;
    assign wait_f      = r_wait_f;
    assign wait_m      = r_wait_m;
    assign qfull_f     = r_qfull_f;
    assign qfull_m     = r_qfull_m;
    assign led_free_f  = r_led_free_f;
    assign led_free_m  = r_led_free_m;

endmodule
